imem_loader: RTL and testbench

//   Writer side of the instruction-memory interface: the processor only reads instruction memory
//   (word address = PC, PC steps by 1). This block fills that memory.
//   - Input: a byte stream with valid/ready handshake.
//   - Assembles big-endian 32-bit words and writes them to consecutive word addresses from 0.
//   - Holds the processor in reset (cpu_hold) until the load completes.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them to consecutive word addresses from 0 and holds the CPU in reset until done.
module imem_loader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [WIDTH-1:0]    word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;

    logic legal_count;
    assign legal_count = (num_words != '0) && (num_words <= MAX_WORDS);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        hold_d  = hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal_count) begin
                        count_d = num_words;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    // NOTE: blocking here is deliberate; word_d is read back below in the same pass.
                    word_d[(WIDTH-1) - 8*int'(bcnt_q) -: 8] = byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wdata_d = word_d;
                        addr_d  = idx_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if ({1'b0, idx_q} == count_q - 1'b1) begin
                    hold_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write-side registers hold their last value outside WRITE; consumers qualify with mem_we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign mem_we     = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign cpu_hold   = hold_q;
    assign mem_addr   = {{(WIDTH-ADDR_W){1'b0}}, addr_q};
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: random program bytes are packed into expected words by a
// simple arithmetic model and compared against the memory writes observed on the DUT.
module tb_imem_loader;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    imem_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and done pulses, sampled mid-cycle.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          hi_bad = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (mem_addr[WIDTH-1:ADDR_W] != '0) hi_bad = hi_bad + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog[$];
    int         acc_cyc[$];
    int         wb = 0;
    int         db = 0;
    int         start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic new_test(input int nbytes);
        prog.delete();
        acc_cyc.delete();
        wb = wr_addr.size();
        db = done_cyc.size();
        for (int i = 0; i < nbytes; i++) prog.push_back(8'($urandom));
    endtask

    task automatic start_load(input int n);
        start     = 1'b1;
        num_words = (ADDR_W+1)'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        @(negedge clk);
        while (!byte_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc.push_back(cyc);
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_load(input int n, input int max_gap, input bit noise);
        int gap;
        for (int i = 0; i < 4*n; i++) begin
            gap = (i == 4*n-1) ? 0 : int'($urandom_range(max_gap, 0));
            if (noise) begin
                start     = 1'b1;
                num_words = (ADDR_W+1)'(7);
            end
            send_byte(prog[i], gap);
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 20) begin
            k++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic expect_model(input string tag, input int n);
        int          got;
        logic [31:0] exp_word;
        got = wr_addr.size() - wb;
        check({tag, "_nwrites"}, 32'(got), 32'(n));
        for (int w = 0; w < n && w < got; w++) begin
            exp_word = (32'(prog[4*w]) << 24) | (32'(prog[4*w+1]) << 16)
                     | (32'(prog[4*w+2]) << 8) | 32'(prog[4*w+3]);
            check({tag, "_addr"}, wr_addr[wb+w], 32'(w));
            check({tag, "_data"}, wr_data[wb+w], exp_word);
            check({tag, "_latency"}, 32'(wr_cyc[wb+w]), 32'(acc_cyc[4*w+3]));
        end
        check({tag, "_ndone"}, 32'(done_cyc.size() - db), 32'd1);
        if (got >= n && done_cyc.size() > db)
            check({tag, "_done_after_last"}, 32'(done_cyc[db]), 32'(wr_cyc[wb+n-1] + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Two words at full rate with known bytes
        new_test(0);
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        start_load(2);
        check("t1_hold_loading", 32'(cpu_hold), 32'd1);
        check("t1_busy_loading", 32'(busy), 32'd1);
        do_load(2, 0, 1'b0);
        wait_done("t1");
        expect_model("t1", 2);
        check("t1_wdata_holds", mem_wdata, 32'h8C09_0000);
        check("t1_addr_holds", mem_addr, 32'd1);

        // Seven-cycle stall between bytes 2 and 3
        new_test(4);
        start_load(1);
        send_byte(prog[0], 0);
        send_byte(prog[1], 0);
        repeat (7) begin
            @(negedge clk);
            check("t2_stall_ready", 32'(byte_ready), 32'd1);
            check("t2_stall_busy", 32'(busy), 32'd1);
            check("t2_stall_we", 32'(mem_we), 32'd0);
            @(posedge clk); #1;
        end
        send_byte(prog[2], 0);
        send_byte(prog[3], 0);
        wait_done("t2");
        expect_model("t2", 1);
        if (wr_addr.size() > wb)
            check("t2_write_offset", 32'(wr_cyc[wb] - start_cyc), 32'd11);

        // Illegal counts, then a legal start clears err
        new_test(0);
        start_load(0);
        check("t3_err_zero", 32'(err), 32'd1);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_idle_ready", 32'(byte_ready), 32'd0);
        check("t3_hold_unchanged", 32'(cpu_hold), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        start_load(257);
        check("t3_err_257", 32'(err), 32'd1);
        check("t3_busy_257", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_writes", 32'(wr_addr.size() - wb), 32'd0);
        new_test(4);
        start_load(1);
        check("t3_err_cleared", 32'(err), 32'd0);
        check("t3_hold_set", 32'(cpu_hold), 32'd1);
        do_load(1, 1, 1'b0);
        wait_done("t3");
        expect_model("t3", 1);

        // Reset mid-load, then a clean reload
        new_test(12);
        start_load(3);
        for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        new_test(12);
        start_load(3);
        do_load(3, 2, 1'b0);
        wait_done("t4");
        expect_model("t4", 3);

        // Full-depth load
        new_test(1024);
        start_load(256);
        do_load(256, 0, 1'b0);
        wait_done("t5");
        expect_model("t5", 256);
        if (wr_addr.size() >= wb + 256)
            check("t5_last_addr", wr_addr[wb+255], 32'h0000_00FF);
        check("t5_addr_high_zero", 32'(hi_bad), 32'd0);

        // start pulses while loading and writing are ignored
        new_test(12);
        start_load(3);
        do_load(3, 1, 1'b1);
        wait_done("t6");
        expect_model("t6", 3);
        repeat (5) @(negedge clk);
        check("t6_no_extra_writes", 32'(wr_addr.size() - wb), 32'd3);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
